// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Holds the FSM state encoding, default timing limits, command bytes and the frame layout.
package ps2_host_tx_pkg;

    localparam int unsigned INHIBIT_CYCLES_DEF = 12000;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 2000000;

    localparam int unsigned FRAME_W   = 11;
    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned LAST_FALL = 10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_RESET    = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_BITS,
        ST_ACK,
        ST_RELEASE
    } state_t;

    // Wire order of one host-to-device frame; the start bit sits in the LSB.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
        logic       start;
    } frame_t;

    function automatic frame_t build_frame(input logic [7:0] data);
        frame_t f;
        f.stop   = 1'b1;
        f.parity = ~^data;
        f.data   = data;
        f.start  = 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizer for one raw PS/2 pin plus a falling-edge strobe.
// Module name ps2_line_sync so the PS/2 receiver can share it.
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic fall_c
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Idle bus level is high, so reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= line;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level  = sync_q;
    assign fall_c = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, ACK.
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);

    logic clk_sync;
    logic clk_fall;
    logic data_sync;
    logic unused_data_fall;

    ps2_line_sync u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line   (ps2_clk_in),
        .level  (clk_sync),
        .fall_c (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .line   (ps2_data_in),
        .level  (data_sync),
        .fall_c (unused_data_fall)
    );

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]     inh_cnt_q, inh_cnt_d;
    logic                 err_q, err_d;
    logic                 tx_ready_d, busy_d, done_d, ack_err_d;
    logic                 clk_oe_d, data_oe_d;
    logic                 timeout_c;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;

    // Reloaded while idle so the accept cycle counts as the first transfer cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else if (state_q == ST_IDLE) begin
            to_cnt_q <= TO_W'(1);
        end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    assign timeout_c = (state_q != ST_IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        inh_cnt_d  = inh_cnt_q;
        err_d      = err_q;
        clk_oe_d   = ps2_clk_oe;
        data_oe_d  = ps2_data_oe;
        done_d     = 1'b0;
        ack_err_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    shift_d   = build_frame(tx_data);
                    inh_cnt_d = '0;
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
                    data_oe_d = 1'b1;
                    shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
                    state_d   = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            ST_RTS: begin
                clk_oe_d  = 1'b0;
                bit_cnt_d = '0;
                state_d   = ST_BITS;
            end
            // Device samples on its rising edge, so the next bit goes out after each fall.
            ST_BITS: begin
                if (clk_fall) begin
                    data_oe_d = ~shift_q[0];
                    shift_d   = {1'b1, shift_q[FRAME_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(LAST_FALL - 1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    err_d   = data_sync;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (clk_sync && data_sync) begin
                    done_d    = 1'b1;
                    ack_err_d = err_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (timeout_c) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_err_d = 1'b1;
            state_d   = ST_IDLE;
        end

        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_q     <= '1;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            err_q       <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            err_q       <= err_d;
            tx_ready    <= tx_ready_d;
            busy        <= busy_d;
            done        <= done_d;
            ack_err     <= ack_err_d;
            ps2_clk_oe  <= clk_oe_d;
            ps2_data_oe <= data_oe_d;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model on open-drain lines records received frames.
// Expected frames and ACK status come from a byte-level model; a monitor compares on every done.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int unsigned INH    = 100;
    localparam int unsigned TMO    = 5000;
    localparam int          H      = 20;
    localparam int          BUDGET = 8000;

    typedef struct {
        logic [7:0] data;
        logic       exp_err;
        logic       has_frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, ack_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic dev_no_ack = 1'b0;
    logic dev_silent = 1'b0;
    logic dev_discard = 1'b0;
    logic dev_active = 1'b0;
    logic measure_lat = 1'b0;
    int   dev_falls = 0;

    exp_t       exp_q[$];
    logic [9:0] rx_q[$];
    int checks = 0;
    int fails = 0;
    int done_cnt = 0;
    int n_sent = 0;

    assign ps2_clk_in  = ~ps2_clk_oe & ~dev_clk_low;
    assign ps2_data_in = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Bit i is what the device should read on rising edge i+1.
    function automatic logic [9:0] model_frame(input logic [7:0] b);
        logic [9:0] f;
        f[7:0] = b;
        f[8]   = ($countones(b) % 2 == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    task automatic dev_frame();
        logic [9:0] bits;
        int lat;
        bits = '0;
        dev_active = 1'b1;
        dev_falls = 0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            dev_clk_low = 1'b1;
            dev_falls++;
            if (i == 0 && measure_lat) begin
                lat = 0;
                while (ps2_data_oe && lat < 10) begin
                    @(negedge clk);
                    lat++;
                end
                check("data_update_latency", 32'(lat), 3);
                repeat (H - lat) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
            bits[i] = ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        dev_data_low = ~dev_no_ack;
        repeat (4) @(negedge clk);
        dev_clk_low = 1'b1;
        dev_falls++;
        repeat (H) @(negedge clk);
        dev_clk_low = 1'b0;
        @(negedge clk);
        dev_data_low = 1'b0;
        if (dev_discard) dev_discard = 1'b0;
        else rx_q.push_back(bits);
        repeat (H) @(negedge clk);
        dev_active = 1'b0;
    endtask

    // Device responds to request-to-send: clock released high, data pulled low.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && !dev_silent && ps2_clk_in && !ps2_data_in) dev_frame();
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] r;
        if (rst_n && done) begin
            done_cnt++;
            check("exp_queue_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("ack_err", 32'(ack_err), 32'(e.exp_err));
                check("ready_with_done", 32'(tx_ready), 1);
                check("busy_with_done", 32'(busy), 0);
                check("clk_oe_at_done", 32'(ps2_clk_oe), 0);
                check("data_oe_at_done", 32'(ps2_data_oe), 0);
                if (e.has_frame) begin
                    check("rx_frame_present", 32'(rx_q.size() != 0), 1);
                    if (rx_q.size() != 0) begin
                        r = rx_q.pop_front();
                        check("rx_frame_bits", 32'(r), 32'(model_frame(e.data)));
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic no_ack, input logic has_frame,
                        input logic timing, input logic poke, output int cyc);
        exp_t e;
        int   c;
        int   clk_low;
        int   data_first;
        dev_no_ack = no_ack;
        c = 0;
        while (!tx_ready && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        check("ready_before_send", 32'(tx_ready), 1);
        e.data = b;
        e.exp_err = no_ack | ~has_frame;
        e.has_frame = has_frame;
        exp_q.push_back(e);
        n_sent++;
        tx_valid = 1'b1;
        tx_data = b;
        @(negedge clk);
        tx_valid = 1'b0;
        cyc = 1;
        if (timing) begin
            check("busy_after_accept", 32'(busy), 1);
            check("ready_after_accept", 32'(tx_ready), 0);
            clk_low = 0;
            data_first = 0;
            while (ps2_clk_oe && cyc < 1000) begin
                if (ps2_data_oe && data_first == 0) data_first = cyc;
                clk_low++;
                @(negedge clk);
                cyc++;
            end
            check("clk_oe_low_cycles", 32'(clk_low), INH + 1);
            check("data_oe_first_cycle", 32'(data_first), INH + 1);
            check("start_bit_held", 32'(ps2_data_oe), 1);
        end
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            tx_valid = poke && (cyc == 50);
            if (tx_valid) tx_data = ~b;
        end
        tx_valid = 1'b0;
        check("done_within_budget", 32'(done), 1);
    endtask

    task automatic reset_mid();
        int c;
        dev_no_ack = 1'b0;
        dev_discard = 1'b1;
        dev_falls = 0;
        tx_valid = 1'b1;
        tx_data = 8'hA5;
        @(negedge clk);
        tx_valid = 1'b0;
        c = 0;
        while (dev_falls < 4 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        check("reached_bit4", 32'(dev_falls >= 4), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(tx_ready), 1);
        c = 0;
        while (dev_active && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        check("device_finished", 32'(dev_active), 0);
        check("no_done_after_reset", 32'(done_cnt), 32'(n_sent));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [7:0] b;
        logic na;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", 32'(tx_ready), 1);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ack_err", 32'(ack_err), 0);
        check("reset_clk_oe", 32'(ps2_clk_oe), 0);
        check("reset_data_oe", 32'(ps2_data_oe), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        measure_lat = 1'b1;
        send(CMD_SET_LEDS, 1'b0, 1'b1, 1'b1, 1'b0, cyc);
        measure_lat = 1'b0;
        send(8'h01, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
        send(CMD_RESET, 1'b0, 1'b1, 1'b0, 1'b1, cyc);
        send(CMD_ENABLE, 1'b1, 1'b1, 1'b0, 1'b0, cyc);

        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            na = ($urandom_range(0, 3) == 0);
            send(b, na, 1'b1, 1'b0, (i == 2), cyc);
        end

        reset_mid();
        send(CMD_RESET, 1'b0, 1'b1, 1'b0, 1'b0, cyc);

`ifdef PS2_TX_TIMEOUT_EN
        dev_silent = 1'b1;
        send(CMD_ENABLE, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        check("timeout_cycle", 32'(cyc), TMO);
        dev_silent = 1'b0;
`endif

        repeat (10) @(negedge clk);
        check("done_count", 32'(done_cnt), 32'(n_sent));
        check("exp_queue_drained", 32'(exp_q.size()), 0);
        check("rx_queue_drained", 32'(rx_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port: accepts one command byte from the memory-mapped I/O block (e.g. keyboard LED set 0xED, reset 0xFF) and drives it onto the open-drain PS/2 clock/data lines. It frames the byte per the PS/2 host-to-device protocol: inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, then device ACK. It sits beside the existing PS/2 receiver and asserts `busy` so the receiver ignores bus activity it generates.

## Interface
- `INHIBIT_CYCLES`, 12000: cycles clock is held low before request-to-send (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, 2000000: watchdog limit per transfer (20 ms at 100 MHz); used only with the timeout feature.
- `clk`  in  1  system clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_data`  in  8  command byte.
- `tx_ready`  out  1  idle, can accept; transfer occurs when `tx_valid && tx_ready`.
- `ps2_clk_in`, `ps2_data_in`  in  1 each  raw pin levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1 each  1 = pull line low, 0 = release (pad is open-drain).
- `busy`  out  1  transfer in progress; receiver gating.
- `done`  out  1  one-cycle pulse at end of transfer.
- `ack_err`  out  1  valid with `done`: 1 = no ACK or timeout.

## Operation
- Pin inputs pass through 2-flop synchronizers; a third register gives `clk_fall` = prev 1 and current 0.
- States: IDLE, INHIBIT, RTS, BITS, ACK, RELEASE.
- IDLE: `tx_ready`=1, both oe=0. On accept, latch byte, compute parity = ~^byte, load 11-bit shift {1 stop, parity, byte}, enter INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly INHIBIT_CYCLES cycles, then RTS.
- RTS: `ps2_data_oe`=1 and `ps2_clk_oe`=1 for one cycle, then clk_oe=0 (start bit held low), go BITS with bit count 0.
- BITS: on each `clk_fall`, present next shift bit: `ps2_data_oe` = ~bit. Falls 1–8 data bits, 9 parity, 10 stop (data released). After fall 10, go ACK.
- ACK: on fall 11, sample synchronized data; 0 = ACK good, 1 = `ack_err` set. Go RELEASE.
- RELEASE: wait until synchronized clk and data both 1, then pulse `done`, return IDLE.
- `tx_valid` while not ready is ignored; no queueing.
- Reset mid-transfer: all oe released immediately (async), state IDLE; device recovers by its own timeout.

## Timing
- Reset values: `tx_ready`=1, `busy`=0, `done`=0, `ack_err`=0, both oe=0.
- `busy` = ~`tx_ready`; rises the cycle after accept.
- `ps2_clk_oe` rises cycle after accept; high for INHIBIT_CYCLES+1 cycles total (incl. RTS cycle).
- Data update latency: 3 `clk` cycles from pin falling edge to `ps2_data_oe` change (well within 30 µs low phase).
- `done` fires 1 cycle after both lines seen high; `tx_ready` returns same cycle as `done`.
- Back-to-back: new accept possible the cycle `tx_ready` is 1.

## Configuration
- `PS2_TX_TIMEOUT_EN` defined: counter clears on accept, counts every non-IDLE cycle; at TIMEOUT_CYCLES, release both lines, pulse `done` with `ack_err`=1, IDLE.
- Undefined: no counter; a silent device leaves the block waiting in BITS/ACK/RELEASE until reset.

## Structure
- Shared package: state enum, default INHIBIT/TIMEOUT constants, PS/2 command constants (0xED, 0xF4, 0xFF).
- One sub-module: `ps2_line_sync` (2-flop sync + falling-edge detect), reusable by the receiver.

## Test plan
- Device model clocks at 12 kHz; send 0xED -> bits on rising edges 1,0,1,1,0,1,1,1, parity 1, stop 1; model ACKs; `done`=1, `ack_err`=0.
- Send 0x01 -> parity 0; send 0xFF -> parity 1; model checks both frames.
- Model omits ACK (data high on fall 11) for 0xF4 -> `done` with `ack_err`=1.
- `clk_oe` low-time check: INHIBIT_CYCLES=100 -> clk held low exactly 101 cycles, data low from cycle 101.
- With `PS2_TX_TIMEOUT_EN`, TIMEOUT_CYCLES=5000, model never clocks -> `done`,`ack_err`=1 at cycle 5000, oe both 0.
- Assert `rst_n`=0 during bit 4 -> oe both 0 same cycle, `tx_ready`=1 after release; next 0xFF transfer completes cleanly.
